// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
// busca_instrucao: instruction fetch stage (PC, capture register, run FSM)
// Rev 1.0
// ============================================================================
module busca_instrucao #(
  parameter logic [7:0] END_FINAL = 8'hFF,
  parameter logic [7:0] END_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inicio,
  input  logic [7:0] end_inicio,
  input  logic       espera,
  input  logic       desvio,
  input  logic [7:0] alvo,
  input  logic [7:0] instrucao,
  output logic [7:0] endereco,
  output logic [7:0] instr_reg,
  output logic [7:0] pc_instr,
  output logic       instr_valida,
  output logic       executando,
  output logic [7:0] contador
);

  localparam logic [1:0] S_OCIOSO = 2'd0;
  localparam logic [1:0] S_BUSCA  = 2'd1;
  localparam logic [1:0] S_FIM    = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next_state;

  logic [7:0] r_pc;
  logic [7:0] r_instr;
  logic [7:0] r_pc_instr;
  logic       r_valida;
  logic [7:0] r_contador;

  logic       w_em_busca;
  logic       w_start;
  logic       w_desvio;
  logic       w_espera;
  logic       w_fetch;
  logic       w_halt;
  logic [7:0] w_cont_inc;

  // Branch beats stall, stall beats fetch; all three only matter in BUSCA.
  assign w_em_busca = (r_state == S_BUSCA);
  assign w_start    = !w_em_busca && inicio;
  assign w_desvio   = w_em_busca && desvio;
  assign w_espera   = w_em_busca && !desvio && espera;
  assign w_fetch    = w_em_busca && !desvio && !espera;
  assign w_halt     = w_fetch && (r_pc == END_FINAL);
  assign w_cont_inc = (r_contador == 8'hFF) ? 8'hFF : r_contador + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_OCIOSO;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_OCIOSO: if (inicio) w_next_state = S_BUSCA;
      S_BUSCA:  if (w_halt) w_next_state = S_FIM;
      S_FIM:    if (inicio) w_next_state = S_BUSCA;
      default:  w_next_state = S_OCIOSO;
    endcase
  end

  always_comb begin
    executando = (r_state == S_BUSCA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= END_RESET;
      r_instr    <= 8'h00;
      r_pc_instr <= 8'h00;
      r_valida   <= 1'b0;
      r_contador <= 8'h00;
    end else if (w_start) begin
      r_pc       <= end_inicio;
      r_contador <= 8'h00;
      r_valida   <= 1'b0;
    end else if (w_desvio) begin
      r_pc     <= alvo;
      r_valida <= 1'b0;
    end else if (w_fetch) begin
      r_instr    <= instrucao;
      r_pc_instr <= r_pc;
      r_valida   <= 1'b1;
      r_pc       <= r_pc + 8'd1;
      r_contador <= w_cont_inc;
    end else if (!w_espera) begin
      // Idle or finished: drop the valid flag, everything else holds.
      r_valida <= 1'b0;
    end
  end

  assign endereco     = r_pc;
  assign instr_reg    = r_instr;
  assign pc_instr     = r_pc_instr;
  assign instr_valida = r_valida;
  assign contador     = r_contador;

endmodule
`default_nettype wire

// File: tb/tb_busca_instrucao.sv
`default_nettype none
// ============================================================================
// tb_busca_instrucao: directed self-checking bench for busca_instrucao
// Rev 1.0
// ============================================================================
module tb_busca_instrucao;

  logic       clk;
  logic       rst;
  logic       inicio;
  logic [7:0] end_inicio;
  logic       espera;
  logic       desvio;
  logic [7:0] alvo;

  logic [7:0] instr_a, end_a, ireg_a, pci_a, cont_a;
  logic       val_a, exec_a;
  logic [7:0] instr_b, end_b, ireg_b, pci_b, cont_b;
  logic       val_b, exec_b;

  int errs;
  int checks;

  // Memory model: data = address + 0x10
  assign instr_a = end_a + 8'h10;
  assign instr_b = end_b + 8'h10;

  busca_instrucao #(.END_FINAL(8'd44), .END_RESET(8'h00)) dut_a (
    .clk(clk), .rst(rst), .inicio(inicio), .end_inicio(end_inicio),
    .espera(espera), .desvio(desvio), .alvo(alvo), .instrucao(instr_a),
    .endereco(end_a), .instr_reg(ireg_a), .pc_instr(pci_a),
    .instr_valida(val_a), .executando(exec_a), .contador(cont_a)
  );

  busca_instrucao #(.END_FINAL(8'h01), .END_RESET(8'h00)) dut_b (
    .clk(clk), .rst(rst), .inicio(inicio), .end_inicio(end_inicio),
    .espera(espera), .desvio(desvio), .alvo(alvo), .instrucao(instr_b),
    .endereco(end_b), .instr_reg(ireg_b), .pc_instr(pci_b),
    .instr_valida(val_b), .executando(exec_b), .contador(cont_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start(input logic [7:0] a);
    inicio = 1'b1;
    end_inicio = a;
    tick();
    inicio = 1'b0;
  endtask

  initial begin
    errs = 0; checks = 0;
    rst = 1'b1; inicio = 1'b0; end_inicio = 8'h00;
    espera = 1'b0; desvio = 1'b0; alvo = 8'h00;
    #12;
    chk("rst_endereco", end_a, 8'h00);
    chk("rst_instr_reg", ireg_a, 8'h00);
    chk("rst_pc_instr", pci_a, 8'h00);
    chk("rst_valida", val_a, 0);
    chk("rst_exec", exec_a, 0);
    chk("rst_contador", cont_a, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_exec", exec_a, 0);

    // Sequential run 41..44 then halt
    start(8'd41);
    chk("seq_exec", exec_a, 1);
    chk("seq_pc_loaded", end_a, 8'd41);
    chk("seq_valida0", val_a, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_instr", ireg_a, 8'h39 + i);
      chk("seq_pc_instr", pci_a, 8'd41 + i);
      chk("seq_valida", val_a, 1);
    end
    chk("seq_fim_exec", exec_a, 0);
    chk("seq_contador", cont_a, 8'd4);
    chk("seq_pc_after", end_a, 8'd45);
    tick();
    chk("seq_valida_drop", val_a, 0);
    chk("seq_instr_hold", ireg_a, 8'h3C);
    desvio = 1'b1; alvo = 8'd7; espera = 1'b1;
    tick();
    desvio = 1'b0; espera = 1'b0;
    chk("fim_ignores_desvio", end_a, 8'd45);

    // Branch in cycle 2
    start(8'd0);
    chk("br_contador0", cont_a, 8'd0);
    tick();
    chk("br_first", ireg_a, 8'h10);
    desvio = 1'b1; alvo = 8'd20;
    tick();
    desvio = 1'b0;
    chk("br_flush_valida", val_a, 0);
    chk("br_pc_target", end_a, 8'd20);
    chk("br_contador_hold", cont_a, 8'd1);
    tick();
    chk("br_instr", ireg_a, 8'h24);
    chk("br_pc_instr", pci_a, 8'd20);
    chk("br_valida", val_a, 1);
    chk("br_contador", cont_a, 8'd2);
    inicio = 1'b1; end_inicio = 8'd99;
    tick();
    inicio = 1'b0;
    chk("busy_inicio_ign", ireg_a, 8'h25);
    chk("busy_inicio_pc", end_a, 8'd22);

    // Stall for 3 cycles after 0x12
    do_reset();
    start(8'd0);
    tick(); tick(); tick();
    chk("st_captured", ireg_a, 8'h12);
    espera = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_instr", ireg_a, 8'h12);
      chk("st_endereco", end_a, 8'd3);
      chk("st_valida", val_a, 1);
    end
    chk("st_contador", cont_a, 8'd3);
    espera = 1'b0;
    tick();
    chk("st_resume", ireg_a, 8'h13);
    chk("st_contador2", cont_a, 8'd4);

    // Wrap: start at FE, END_FINAL = 01 (dut_b)
    do_reset();
    start(8'hFE);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_instr", ireg_b, 8'h0E + i);
    end
    chk("wr_pc_instr", pci_b, 8'h01);
    chk("wr_halt", exec_b, 0);
    chk("wr_pc_after", end_b, 8'h02);
    chk("wr_contador", cont_b, 8'd4);

    // Branch coincident with END_FINAL (dut_a, END_FINAL = 44)
    do_reset();
    start(8'd42);
    tick(); tick();
    chk("bf_at_final", end_a, 8'd44);
    desvio = 1'b1; alvo = 8'd10;
    tick();
    desvio = 1'b0;
    chk("bf_no_halt", exec_a, 1);
    chk("bf_pc", end_a, 8'd10);
    chk("bf_valida", val_a, 0);
    tick();
    chk("bf_instr", ireg_a, 8'h1A);
    chk("bf_still_run", exec_a, 1);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1; inicio = 1'b1; end_inicio = 8'd50;
    #1;
    chk("ar_exec", exec_a, 0);
    chk("ar_endereco", end_a, 8'h00);
    chk("ar_instr", ireg_a, 8'h00);
    chk("ar_pc_instr", pci_a, 8'h00);
    chk("ar_valida", val_a, 0);
    chk("ar_contador", cont_a, 8'h00);
    tick();
    chk("ar_inicio_ign", exec_a, 0);
    rst = 1'b0; inicio = 1'b0;
    tick();
    chk("ar_stays_idle", exec_a, 0);
    chk("ar_pc_idle", end_a, 8'h00);

    // Saturation: branch loop 0..30
    start(8'd0);
    for (int i = 0; i < 350; i++) begin
      desvio = (end_a == 8'd30);
      alvo = 8'd0;
      tick();
      if (i == 100) chk("sat_mid", cont_a, 8'd98);
    end
    desvio = 1'b0;
    chk("sat_contador", cont_a, 8'hFF);
    chk("sat_exec", exec_a, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter END_FINAL, default 8'hFF, the last program address; capturing it ends the program.
REQ-002 SHALL have parameter END_RESET, default 8'h00, the PC value after reset.
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port inicio  input  1  start pulse; loads end_inicio into the PC.
REQ-006 SHALL have port end_inicio  input  8  start address of the program.
REQ-007 SHALL have port espera  input  1  stall request from the decoder.
REQ-008 SHALL have port desvio  input  1  taken branch or jump.
REQ-009 SHALL have port alvo  input  8  branch or jump target address.
REQ-010 SHALL have port instrucao  input  8  combinational read data from instruction memory.
REQ-011 SHALL have port endereco  output  8  instruction memory address; equals the PC combinationally.
REQ-012 SHALL have port instr_reg  output  8  captured instruction.
REQ-013 SHALL have port pc_instr  output  8  address of the captured instruction.
REQ-014 SHALL have port instr_valida  output  1  instr_reg holds a valid, unconsumed instruction.
REQ-015 SHALL have port executando  output  1  high while the FSM is in BUSCA.
REQ-016 SHALL have port contador  output  8  count of instructions captured since start, saturating.

Function
REQ-017 SHALL implement FSM states OCIOSO, BUSCA and FIM; executando = (state == BUSCA).
REQ-018 In OCIOSO or FIM, an inicio pulse SHALL make the next edge set pc = end_inicio, contador = 0, instr_valida = 0, and state = BUSCA.
REQ-019 inicio SHALL be ignored while in BUSCA.
REQ-020 Priority in BUSCA SHALL be desvio, then espera, then normal fetch.
REQ-021 Normal fetch in BUSCA SHALL, at each edge:
- instr_reg <= instrucao
- pc_instr <= pc
- instr_valida <= 1
- pc <= pc + 1 (mod 256, so 8'hFF wraps to 8'h00)
- contador <= contador + 1, saturating at 8'hFF
REQ-022 A normal fetch from pc == END_FINAL SHALL capture that instruction, then go to FIM; pc is left at END_FINAL + 1 (mod 256).
REQ-023 desvio in BUSCA SHALL set pc <= alvo and instr_valida <= 0 (flush), with no capture and no contador change.
- The instruction at alvo is captured at the following edge.
- desvio overrides an END_FINAL halt in the same cycle.
REQ-024 espera in BUSCA (with desvio low) SHALL hold pc, instr_reg, pc_instr, instr_valida and contador.
REQ-025 In OCIOSO and FIM, pc, instr_reg, pc_instr and contador SHALL hold, and instr_valida SHALL be cleared at the next edge.
REQ-026 Fetch latency from a PC value to instr_reg SHALL be one clock edge; steady-state throughput SHALL be one instruction per cycle.
REQ-027 desvio, espera and alvo SHALL be ignored outside BUSCA.

Reset
REQ-028 rst high SHALL immediately, without waiting for a clock edge, force:
- state = OCIOSO
- pc = END_RESET
- instr_reg = 8'h00, pc_instr = 8'h00, contador = 8'h00
- instr_valida = 0, executando = 0
REQ-029 Reset asserted mid-fetch SHALL abort the program; a fresh inicio is required to resume.
REQ-030 The first edge after rst deasserts SHALL behave as OCIOSO with the current inputs.

Verification
The bench memory model returns instrucao = endereco + 8'h10 combinationally.
REQ-031 Sequential run: reset, then inicio with end_inicio = 8'd41 and END_FINAL = 8'd44 -> instr_reg = 8'h39, 8'h3A, 8'h3B, 8'h3C on consecutive edges; then FIM; contador = 4; instr_valida drops one cycle after the last capture.
REQ-032 Branch: start at 0, desvio with alvo = 8'd20 in cycle 2 -> one cycle with instr_valida = 0, then instr_reg = 8'h24 with pc_instr = 8'd20; contador excludes the flushed slot.
REQ-033 Stall: espera held for 3 cycles after capturing 8'h12 -> instr_reg stays 8'h12, endereco stays 8'd3, instr_valida stays 1; fetch resumes with 8'h13.
REQ-034 Boundaries:
- Start at 8'hFE with END_FINAL = 8'h01 -> captures 8'h0E, 8'h0F, 8'h10, 8'h11 (pc wraps), then halts.
- desvio coinciding with pc == END_FINAL -> branch taken, no halt.
REQ-035 Asynchronous reset: assert rst between clock edges during BUSCA -> all outputs take their REQ-028 values before the next edge; inicio ignored while rst is high.
REQ-036 Saturation: run 300 fetches with END_FINAL unreachable (branch loop) -> contador stays at 8'hFF.
